pass_tx: RTL

//  Serial password transmitter; the sending end of the pass checker's bit-serial input.
//  On start, latches a CODE_W-bit code and emits a clear bit period (pass_clr) on out,

---
 rtl/pass_tx_if.sv | 24 ++
 rtl/pass_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pass_tx_if.sv
// Interface pass_tx_if: start/code request side and the serial/status outputs of pass_tx.
// The transmitter uses the slave modport. A driver or board-level wrapper uses the master modport.
`timescale 1ns/1ps
interface pass_tx_if #(
   parameter int CODE_W = 8
);
   logic              start;
   logic [CODE_W-1:0] code;
   logic              out;
   logic              pass_clr;
   logic              busy;
   logic              done;
   logic [7:0]        LED;

   modport master (
      output start, code,
      input  out, pass_clr, busy, done, LED
   );

   modport slave (
      input  start, code,
      output out, pass_clr, busy, done, LED
   );
endinterface

// File: rtl/pass_tx.sv
// Module pass_tx: serial password transmitter feeding the pass checker.
// A frame is one clear period (pass_clr high, out low), followed by the latched code sent MSB-first.
// Each period lasts BIT_TICKS clocks. LED shows the most recent eight bits that were sent.
// Optional feature: define PASS_TX_PARITY_EN to append one even-parity bit after the code.
`timescale 1ns/1ps
module pass_tx #(
   parameter int CODE_W    = 8,
   parameter int BIT_TICKS = 50_000_000
) (
   input  logic       clk,
   input  logic       reset_local,
   pass_tx_if.slave   bus
);
   localparam int TICK_W = $clog2(BIT_TICKS);
   localparam int IDX_W  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [IDX_W-1:0]  IDX_MSB   = IDX_W'(CODE_W - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_SEND = 3'd2,
      S_PAR  = 3'd3,
      S_DONE = 3'd4
   } state_t;

`ifdef PASS_TX_PARITY_EN
   // Even parity over the latched code: the transmitted bit makes the total count of ones even.
   function automatic logic even_parity(input logic [CODE_W-1:0] v);
      return ^v;
   endfunction
`endif

   state_t              state_r, state_nxt_s;
   logic [TICK_W-1:0]   tick_r, tick_nxt_s;
   logic [IDX_W-1:0]    idx_r, idx_nxt_s;
   logic [CODE_W-1:0]   code_r, code_nxt_s;
   logic                out_r, out_nxt_s;
   logic                clr_r, clr_nxt_s;
   logic                busy_r, busy_nxt_s;
   logic                done_r, done_nxt_s;
   logic [7:0]          led_r, led_nxt_s;
   logic                tick_end_s;

   assign tick_end_s   = (tick_r == TICK_LAST);
   assign bus.out      = out_r;
   assign bus.pass_clr = clr_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.LED      = led_r;

   // Next-state and next-output logic. Every output is registered one stage later.
   always_comb begin
      state_nxt_s = state_r;
      tick_nxt_s  = tick_r;
      idx_nxt_s   = idx_r;
      code_nxt_s  = code_r;
      out_nxt_s   = out_r;
      clr_nxt_s   = clr_r;
      busy_nxt_s  = busy_r;
      done_nxt_s  = 1'b0;
      led_nxt_s   = led_r;
      case (state_r)
         // DONE also accepts a new start, so a held start gives back-to-back frames.
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_nxt_s = S_CLR;
               code_nxt_s  = bus.code;
               tick_nxt_s  = {TICK_W{1'b0}};
               busy_nxt_s  = 1'b1;
               clr_nxt_s   = 1'b1;
               out_nxt_s   = 1'b0;
               led_nxt_s   = 8'h00;
            end else begin
               state_nxt_s = S_IDLE;
               tick_nxt_s  = {TICK_W{1'b0}};
               busy_nxt_s  = 1'b0;
               clr_nxt_s   = 1'b0;
               out_nxt_s   = 1'b0;
            end
         end
         S_CLR: begin
            if (tick_end_s) begin
               state_nxt_s = S_SEND;
               tick_nxt_s  = {TICK_W{1'b0}};
               idx_nxt_s   = IDX_MSB;
               clr_nxt_s   = 1'b0;
               out_nxt_s   = code_r[CODE_W-1];
            end else begin
               tick_nxt_s  = tick_r + TICK_ONE;
            end
         end
         S_SEND: begin
            if (tick_end_s) begin
               tick_nxt_s = {TICK_W{1'b0}};
               led_nxt_s  = {led_r[6:0], code_r[idx_r]};
               if (idx_r == {IDX_W{1'b0}}) begin
`ifdef PASS_TX_PARITY_EN
                  state_nxt_s = S_PAR;
                  out_nxt_s   = even_parity(code_r);
`else
                  state_nxt_s = S_DONE;
                  out_nxt_s   = 1'b0;
                  done_nxt_s  = 1'b1;
`endif
               end else begin
                  idx_nxt_s = idx_r - IDX_ONE;
                  out_nxt_s = code_r[idx_r - IDX_ONE];
               end
            end else begin
               tick_nxt_s = tick_r + TICK_ONE;
            end
         end
         S_PAR: begin
            if (tick_end_s) begin
               state_nxt_s = S_DONE;
               tick_nxt_s  = {TICK_W{1'b0}};
               led_nxt_s   = {led_r[6:0], out_r};
               out_nxt_s   = 1'b0;
               done_nxt_s  = 1'b1;
            end else begin
               tick_nxt_s  = tick_r + TICK_ONE;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
            tick_nxt_s  = {TICK_W{1'b0}};
            idx_nxt_s   = {IDX_W{1'b0}};
            out_nxt_s   = 1'b0;
            clr_nxt_s   = 1'b0;
            busy_nxt_s  = 1'b0;
            led_nxt_s   = 8'h00;
         end
      endcase
   end

   // State and output registers. An asynchronous reset aborts any frame in progress.
   always_ff @(posedge clk or negedge reset_local) begin
      if (!reset_local) begin
         state_r <= S_IDLE;
         tick_r  <= {TICK_W{1'b0}};
         idx_r   <= {IDX_W{1'b0}};
         code_r  <= {CODE_W{1'b0}};
         out_r   <= 1'b0;
         clr_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         led_r   <= 8'h00;
      end else begin
         state_r <= state_nxt_s;
         tick_r  <= tick_nxt_s;
         idx_r   <= idx_nxt_s;
         code_r  <= code_nxt_s;
         out_r   <= out_nxt_s;
         clr_r   <= clr_nxt_s;
         busy_r  <= busy_nxt_s;
         done_r  <= done_nxt_s;
         led_r   <= led_nxt_s;
      end
   end
endmodule
